meter_timer: RTL
================

# meter_timer

Parking-meter time-keeping core, directly downstream of the button debouncer. It consumes the debounced `up`/`down`/`left`/`right` levels, each high from press until release, and adds a fixed credit on each press. It counts the remaining time down once per second and drives a binary seconds value plus a blink/blank flag to the display stage.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: CLK cycles per second. Must be even and ≥ 4.
- `MAX_TIME`, default 9999: saturation ceiling in seconds.
- `CLK`  in  1  system clock.
- `RESET`  in  1  reset, asynchronous, active-high. Clock is CLK.
- `up`  in  1  debounced level; rising edge adds 10 s.
- `down`  in  1  debounced level; rising edge adds 550 s.
- `left`  in  1  debounced level; rising edge adds 180 s.
- `right`  in  1  debounced level; rising edge adds 200 s.
- `sw_10`  in  1  level; while high, time is forced to 10.
- `sw_205`  in  1  level; while high, time is forced to 205.
- `time_val`  out  14  remaining seconds, 0..MAX_TIME.
- `blank`  out  1  1 = display digits off (blink phase).
- `expired`  out  1  1 when `time_val` == 0.

## Operation
- Edge detect: register each button (`*_q`). A press is `x & ~x_q`. Holding a button adds its credit once only.
  - Same-cycle edges use priority up > down > left > right. Only the winning credit is applied; the others are discarded.
- Prescaler: `pre` counts 0..TICKS_PER_SEC−1 and wraps.
  - `tick` pulses when `pre` == TICKS_PER_SEC−1.
  - `half` pulses when `pre` == TICKS_PER_SEC/2−1.
- Time update, in priority order:
  1. `sw_10` high: `time_val` ← 10 and `pre` ← 0. Button edges are ignored.
  2. `sw_205` high, `sw_10` low: `time_val` ← 205 and `pre` ← 0. Button edges are ignored.
  3. Otherwise: `time_val` ← min(MAX_TIME, `time_val` − dec + add).
     - dec = 1 if `tick` and `time_val` > 0, else 0.
     - add is the credit of the winning edge, else 0.
     - Compute in ≥ 15 bits before saturating. No wrap-around at either end; stays 0 at 0.
- Display-mode FSM. Mode is decoded from the registered `time_val`; `blank` is registered.
  - NORMAL (`time_val` ≥ 200): `blank` = 0; `phase` ← 0.
  - LOW (1..199): 2 s period. On each `tick`, `phase` toggles and `blank` ← new `phase`. The display is on 1 s and off 1 s, starting on.
  - EXPIRED (0): 1 s period, 50 % duty. `blank` ← 1 on `half` and ← 0 on `tick`.
  - On any mode change, `phase` ← 0 and `blank` ← 0 in the same cycle, so every mode starts with digits visible.
- `expired` = (`time_val` == 0), registered together with `time_val`.
- Switch loads also clear `phase` and `blank`.

## Timing
- Reset values: `time_val` = 0, `expired` = 1, `blank` = 0, `pre` = 0, `phase` = 0, all `*_q` = 0.
- After reset the mode is EXPIRED. The first `half` occurs TICKS_PER_SEC/2 cycles after reset is released.
- Button latency: `time_val` shows the credit after the first CLK edge at which `x` = 1 and `x_q` = 0 (1 cycle).
- Tick latency: `time_val` decrements on the edge where `pre` wraps.
- Mode and `blank` change on the cycle after `time_val` crosses a boundary (1-cycle lag).
- Switch load: `time_val` = 10 or 205 one edge after the switch is sampled high. The first decrement comes a full TICKS_PER_SEC cycles after the switch is released.
- A button held through reset does not generate a press on release of reset, because `*_q` is cleared and then reloads. A press already registered when RESET asserts is lost.
- RESET asserted mid-count clears everything immediately, asynchronously.

## Test plan
Run all benches with TICKS_PER_SEC = 10.
- Reset → `time_val` = 0, `expired` = 1, `blank` = 0. `blank` rises at cycle 5 and falls at cycle 10, repeating.
- `right` held 40 cycles from `time_val` = 0 → `time_val` = 200 after 1 cycle (mode NORMAL). After the next tick `time_val` = 199, then LOW blinking with `blank` toggling every 10 cycles.
- `time_val` = 9990, press `down` → `time_val` = 9999 (saturated). `up` and `left` edges in the same cycle → only +10 is applied: 100 → 110.
- Press on the exact tick cycle with `time_val` = 5 and `up` → `time_val` = 14.
- `sw_10` and `sw_205` both high → `time_val` = 10 and holds while the switches are high, even with button presses. Release both → `time_val` = 9 exactly 10 cycles later.
- `time_val` = 1 → 0 on tick; `expired` = 1. Further ticks keep `time_val` at 0. Assert RESET mid-second → `pre` = 0 and `time_val` = 0 immediately.

Source files
------------

// File: rtl/meter_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : meter_timer_if
// Description : Button/switch inputs and display outputs of the parking-meter
//               time-keeping core, grouped into one bundle.
//   up/down/left/right : debounced button levels (credit on rising edge)
//   sw_10 / sw_205     : load switches, level sensitive
//   time_val           : remaining seconds, 0..MAX_TIME
//   blank              : 1 = display digits off (blink phase)
//   expired            : 1 when time_val == 0
//   master : drives buttons/switches, observes display outputs
//   slave  : the timer core itself
// Revision    : 1.0 - initial release
// ============================================================================
interface meter_timer_if;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic        sw_10;
  logic        sw_205;
  logic [13:0] time_val;
  logic        blank;
  logic        expired;

  modport master (
    output up, down, left, right, sw_10, sw_205,
    input  time_val, blank, expired
  );

  modport slave (
    input  up, down, left, right, sw_10, sw_205,
    output time_val, blank, expired
  );
endinterface
`default_nettype wire

// File: rtl/meter_timer.sv
`default_nettype none
// ============================================================================
// Module      : meter_timer
// Description : Parking-meter time-keeping core. Adds a fixed credit per
//               button press, counts the remaining time down once per second
//               and produces a blink/blank flag for the display stage.
//   CLK   : system clock
//   RESET : asynchronous, active-high reset
//   bus   : meter_timer_if.slave (buttons, switches, time_val/blank/expired)
// Parameters:
//   TICKS_PER_SEC : CLK cycles per second (even, >= 4)
//   MAX_TIME      : saturation ceiling in seconds
// Revision    : 1.0 - initial release
// ============================================================================
module meter_timer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MAX_TIME      = 9999
) (
  input  logic         CLK,
  input  logic         RESET,
  meter_timer_if.slave bus
);

  localparam int PRE_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 2;

  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] C_PRE_HALF = PRE_W'(TICKS_PER_SEC / 2 - 1);
  localparam logic [PRE_W-1:0] C_PRE_ONE  = PRE_W'(1);

  localparam logic [15:0] C_MAX       = 16'(MAX_TIME);
  localparam logic [15:0] C_ADD_UP    = 16'd10;
  localparam logic [15:0] C_ADD_DOWN  = 16'd550;
  localparam logic [15:0] C_ADD_LEFT  = 16'd180;
  localparam logic [15:0] C_ADD_RIGHT = 16'd200;
  localparam logic [13:0] C_LOAD_10   = 14'd10;
  localparam logic [13:0] C_LOAD_205  = 14'd205;
  localparam logic [13:0] C_LOW_LIMIT = 14'd200;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_LOW     = 2'd1,
    ST_EXPIRED = 2'd2
  } mode_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic             r_up_q;
  logic             r_down_q;
  logic             r_left_q;
  logic             r_right_q;
  logic             r_arm;
  logic [PRE_W-1:0] r_pre;
  logic [13:0]      r_time;
  logic             r_expired;
  logic             r_blank;
  logic             r_phase;
  mode_t            r_mode;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic             w_press_up;
  logic             w_press_down;
  logic             w_press_left;
  logic             w_press_right;
  logic             w_tick;
  logic             w_half;
  logic             w_load;
  logic             w_dec;
  logic [15:0]      w_add;
  logic [15:0]      w_sum;
  logic [13:0]      w_time_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  mode_t            w_mode_dec;
  mode_t            w_mode_nxt;
  logic             w_phase_nxt;
  logic             w_blank_nxt;

  // Edge detect. r_arm is low only on the first edge after reset, so a
  // button held through reset is absorbed into *_q without being credited.
  assign w_press_up    = r_arm & bus.up    & ~r_up_q;
  assign w_press_down  = r_arm & bus.down  & ~r_down_q;
  assign w_press_left  = r_arm & bus.left  & ~r_left_q;
  assign w_press_right = r_arm & bus.right & ~r_right_q;

  assign w_tick = (r_pre == C_PRE_LAST);
  assign w_half = (r_pre == C_PRE_HALF);
  assign w_load = bus.sw_10 | bus.sw_205;
  assign w_dec  = w_tick && (r_time != 14'd0);

  // Only the highest-priority edge earns credit in a given cycle.
  always_comb begin
    w_add = 16'd0;
    if (w_press_up) begin
      w_add = C_ADD_UP;
    end else if (w_press_down) begin
      w_add = C_ADD_DOWN;
    end else if (w_press_left) begin
      w_add = C_ADD_LEFT;
    end else if (w_press_right) begin
      w_add = C_ADD_RIGHT;
    end
  end

  // w_dec is only set for a non-zero time, so the subtraction cannot wrap;
  // 16 bits hold MAX_TIME plus the largest credit before saturating.
  assign w_sum = {2'b00, r_time} + w_add - {15'd0, w_dec};

  always_comb begin
    w_time_nxt = r_time;
    w_pre_nxt  = r_pre;
    if (bus.sw_10) begin
      w_time_nxt = C_LOAD_10;
      w_pre_nxt  = '0;
    end else if (bus.sw_205) begin
      w_time_nxt = C_LOAD_205;
      w_pre_nxt  = '0;
    end else begin
      w_time_nxt = (w_sum > C_MAX) ? C_MAX[13:0] : w_sum[13:0];
      w_pre_nxt  = w_tick ? '0 : (r_pre + C_PRE_ONE);
    end
  end

  // --------------------------------------------------------------------------
  // Display-mode FSM: mode is decoded from the registered time, so blank
  // lags a boundary crossing by one cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    if (r_time == 14'd0) begin
      w_mode_dec = ST_EXPIRED;
    end else if (r_time < C_LOW_LIMIT) begin
      w_mode_dec = ST_LOW;
    end else begin
      w_mode_dec = ST_NORMAL;
    end
  end

  always_comb begin
    w_mode_nxt  = w_mode_dec;
    w_phase_nxt = r_phase;
    w_blank_nxt = r_blank;
    if (w_load || (w_mode_dec != r_mode)) begin
      // Every mode entry and every switch load starts with digits visible.
      w_phase_nxt = 1'b0;
      w_blank_nxt = 1'b0;
    end else begin
      case (r_mode)
        ST_NORMAL: begin
          w_phase_nxt = 1'b0;
          w_blank_nxt = 1'b0;
        end
        ST_LOW: begin
          if (w_tick) begin
            w_phase_nxt = ~r_phase;
            w_blank_nxt = ~r_phase;
          end
        end
        ST_EXPIRED: begin
          w_phase_nxt = 1'b0;
          if (w_half) begin
            w_blank_nxt = 1'b1;
          end else if (w_tick) begin
            w_blank_nxt = 1'b0;
          end
        end
        default: begin
          w_phase_nxt = 1'b0;
          w_blank_nxt = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_up_q    <= 1'b0;
      r_down_q  <= 1'b0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
      r_arm     <= 1'b0;
      r_pre     <= '0;
      r_time    <= 14'd0;
      r_expired <= 1'b1;
      r_blank   <= 1'b0;
      r_phase   <= 1'b0;
      r_mode    <= ST_EXPIRED;
    end else begin
      r_up_q    <= bus.up;
      r_down_q  <= bus.down;
      r_left_q  <= bus.left;
      r_right_q <= bus.right;
      r_arm     <= 1'b1;
      r_pre     <= w_pre_nxt;
      r_time    <= w_time_nxt;
      r_expired <= (w_time_nxt == 14'd0);
      r_blank   <= w_blank_nxt;
      r_phase   <= w_phase_nxt;
      r_mode    <= w_mode_nxt;
    end
  end

  assign bus.time_val = r_time;
  assign bus.blank    = r_blank;
  assign bus.expired  = r_expired;

endmodule
`default_nettype wire
